// File: rtl/cam_axis_pkg.sv
// Shared types and pixel helpers for the camera-to-AXI-Stream bridge.
// Holds capture FSM states, the output buffer entry and RGB565 expansion.
package cam_axis_pkg;

  typedef enum logic [1:0] {
    WAIT_VS_HIGH = 2'd0,
    WAIT_SOF     = 2'd1,
    ACTIVE       = 2'd2
  } cap_state_t;

  typedef struct packed {
    logic        tuser;
    logic        tlast;
    logic [31:0] tdata;
  } obuf_entry_t;

  // Replicate MSBs so full-scale 565 maps to full-scale 888.
  function automatic logic [31:0] rgb565_to_888(
    input logic [7:0] hi,
    input logic [7:0] lo
  );
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    r = hi[7:3];
    g = {hi[2:0], lo[7:5]};
    b = lo[4:0];
    return {8'h00, r, r[4:2], g, g[5:4], b, b[4:2]};
  endfunction

endpackage

// File: rtl/cam_axis_fifo.sv
// Synchronous first-word-fall-through FIFO with fill count and flags.
// Head entry reads as zero while empty.
module cam_axis_fifo
  import cam_axis_pkg::*;
#(
  parameter int PTR_W  = 9,
  parameter int AF_OFF = 1,
  parameter int AE_OFF = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_n,
  input  logic             wr_en,
  input  obuf_entry_t      wr_data,
  input  logic             rd_en,
  output obuf_entry_t      rd_data,
  output logic             empty,
  output logic             full,
  output logic             almostempty,
  output logic             almostfull,
  output logic [PTR_W-1:0] fill
);

  localparam int DEPTH = 1 << (PTR_W - 1);
  localparam logic [PTR_W-1:0] FULL_LVL = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] AF_LVL = PTR_W'(DEPTH - AF_OFF);
  localparam logic [PTR_W-1:0] AE_LVL = PTR_W'(AE_OFF);
  localparam logic [PTR_W-2:0] PTR_ONE = (PTR_W-1)'(1);
  localparam logic [PTR_W-1:0] CNT_ONE = PTR_W'(1);

  obuf_entry_t      mem [DEPTH];
  logic [PTR_W-2:0] wr_ptr;
  logic [PTR_W-2:0] rd_ptr;
  logic [PTR_W-1:0] cnt;
  logic             push;
  logic             pop;

  assign empty       = (cnt == '0);
  assign full        = (cnt == FULL_LVL);
  assign almostempty = (cnt <= AE_LVL);
  assign almostfull  = (cnt >= AF_LVL);
  assign fill        = cnt;

  // A pop frees the slot a same-cycle push at full needs.
  assign pop  = rd_en && !empty;
  assign push = wr_en && (!full || pop);

  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (!flush_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop) cnt <= cnt + CNT_ONE;
      else if (pop && !push) cnt <= cnt - CNT_ONE;
    end
  end

endmodule

// File: rtl/cam_axis_top.sv
// DVP camera capture: sync, RGB565 byte pairing, RGB888 packing, and
// AXI-Stream output through a FWFT buffer with SOF/EOL sideband.
module cam_axis_top
  import cam_axis_pkg::*;
#(
  parameter int IMG_W              = 640,
  parameter int IMG_H              = 480,
  parameter int FIFO_PTR_WIDTH     = 9,
  parameter int DATA_WIDTH         = 32,
  parameter int ALMOSTFULL_OFFSET  = 1,
  parameter int ALMOSTEMPTY_OFFSET = 1
) (
  input  logic                      i_cfg_clk,
  input  logic                      i_rstn,
  input  logic                      i_obuf_rstn,
  input  logic                      i_cam_pclk,
  input  logic                      i_cam_vsync,
  input  logic                      i_cam_href,
  input  logic [7:0]                i_cam_data,
  input  logic                      M_AXIS_TREADY,
  output logic                      M_AXIS_TVALID,
  output logic                      M_AXIS_TUSER,
  output logic                      M_AXIS_TLAST,
  output logic [DATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic                      o_obuf_empty,
  output logic                      o_obuf_almostempty,
  output logic [FIFO_PTR_WIDTH-1:0] o_obuf_fill,
  output logic                      o_ready
);

  if (DATA_WIDTH != 32 || IMG_W < 2 || IMG_H < 1) begin : g_bad_cfg
    $error("cam_axis_top: unsupported parameter set");
  end

  localparam int XW = $clog2(IMG_W);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [XW-1:0] X_ONE = XW'(1);

  logic [1:0]  pclk_s;
  logic [1:0]  vs_s;
  logic [1:0]  hr_s;
  logic [7:0]  d_s1;
  logic [7:0]  d_s2;
  logic        pclk_d;

  always_ff @(posedge i_cfg_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      pclk_s <= '0;
      vs_s   <= '0;
      hr_s   <= '0;
      d_s1   <= '0;
      d_s2   <= '0;
      pclk_d <= 1'b0;
    end else begin
      pclk_s <= {pclk_s[0], i_cam_pclk};
      vs_s   <= {vs_s[0], i_cam_vsync};
      hr_s   <= {hr_s[0], i_cam_href};
      d_s1   <= i_cam_data;
      d_s2   <= d_s1;
      pclk_d <= pclk_s[1];
    end
  end

  logic sample;
  logic vs;
  logic hr;
  assign sample = pclk_d && !pclk_s[1];
  assign vs     = vs_s[1];
  assign hr     = hr_s[1];

  cap_state_t state_q;
  cap_state_t state_d;

  always_ff @(posedge i_cfg_clk or negedge i_rstn) begin
    if (!i_rstn) state_q <= WAIT_VS_HIGH;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (sample) begin
      unique case (state_q)
        WAIT_VS_HIGH: if (vs) state_d = WAIT_SOF;
        WAIT_SOF:     if (!vs) state_d = ACTIVE;
        ACTIVE:       if (vs) state_d = WAIT_SOF;
        default:      state_d = WAIT_VS_HIGH;
      endcase
    end
  end

  logic        phase_q;
  logic [7:0]  byte0_q;
  logic [XW-1:0] xcnt_q;
  logic        sof_q;
  logic        drop_q;
  logic        push_q;
  obuf_entry_t entry_q;
  obuf_entry_t head;
  logic        obuf_full;
  logic        obuf_almostfull_unused;
  logic        wr_en;
  logic        pop;
  logic        sof_hit;
  logic        act_clr;
  logic        act_pix;
  logic        x_last;

  assign sof_hit = sample && (state_q == WAIT_SOF) && !vs;
  assign act_clr = sample && (state_q == ACTIVE) && (vs || !hr);
  assign act_pix = sample && (state_q == ACTIVE) && !vs && hr;
  assign x_last  = (xcnt_q == X_LAST);
  assign wr_en   = push_q && !drop_q;
  assign pop     = M_AXIS_TVALID && M_AXIS_TREADY;

  always_ff @(posedge i_cfg_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      phase_q <= 1'b0;
      byte0_q <= '0;
      xcnt_q  <= '0;
      sof_q   <= 1'b0;
      drop_q  <= 1'b0;
      push_q  <= 1'b0;
      entry_q <= '0;
    end else begin
      push_q <= 1'b0;
      // Once a pixel is lost the rest of the frame is unusable.
      if (wr_en && obuf_full && !pop) drop_q <= 1'b1;
      unique case (1'b1)
        sof_hit: begin
          sof_q   <= 1'b1;
          drop_q  <= 1'b0;
          phase_q <= 1'b0;
          xcnt_q  <= '0;
        end
        act_clr: begin
          phase_q <= 1'b0;
          xcnt_q  <= '0;
        end
        act_pix && !phase_q: begin
          byte0_q <= d_s2;
          phase_q <= 1'b1;
        end
        act_pix && phase_q: begin
          phase_q <= 1'b0;
          push_q  <= 1'b1;
          sof_q   <= 1'b0;
          xcnt_q  <= x_last ? '0 : xcnt_q + X_ONE;
          entry_q <= '{tuser: sof_q, tlast: x_last,
                       tdata: rgb565_to_888(byte0_q, d_s2)};
        end
        default: ;
      endcase
    end
  end

  cam_axis_fifo #(
    .PTR_W  (FIFO_PTR_WIDTH),
    .AF_OFF (ALMOSTFULL_OFFSET),
    .AE_OFF (ALMOSTEMPTY_OFFSET)
  ) u_obuf (
    .clk         (i_cfg_clk),
    .rst_n       (i_rstn),
    .flush_n     (i_obuf_rstn),
    .wr_en       (wr_en),
    .wr_data     (entry_q),
    .rd_en       (M_AXIS_TREADY),
    .rd_data     (head),
    .empty       (o_obuf_empty),
    .full        (obuf_full),
    .almostempty (o_obuf_almostempty),
    .almostfull  (obuf_almostfull_unused),
    .fill        (o_obuf_fill)
  );

  assign M_AXIS_TVALID = !o_obuf_empty;
  assign M_AXIS_TDATA  = DATA_WIDTH'(head.tdata);
  assign M_AXIS_TUSER  = head.tuser;
  assign M_AXIS_TLAST  = head.tlast;
  assign o_ready       = !o_obuf_empty;

endmodule

// File: tb/tb_cam_axis_top.sv
// Bench for cam_axis_top: random DVP frames, scoreboard of expected beats,
// monitor checking handshake, stall stability and buffer flags.
module tb_cam_axis_top;

  localparam int W = 16;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        obuf_rstn = 1'b1;
  logic        pclk = 1'b0;
  logic        vs = 1'b0;
  logic        hr = 1'b0;
  logic [7:0]  cd = 8'h00;
  logic        tready = 1'b0;
  logic        tvalid;
  logic        tuser;
  logic        tlast;
  logic [31:0] tdata;
  logic        empty;
  logic        aempty;
  logic [8:0]  fill;
  logic        ready;

  always #5 clk = ~clk;

  cam_axis_top #(
    .IMG_W              (W),
    .IMG_H              (24),
    .FIFO_PTR_WIDTH     (9),
    .DATA_WIDTH         (32),
    .ALMOSTFULL_OFFSET  (1),
    .ALMOSTEMPTY_OFFSET (1)
  ) dut (
    .i_cfg_clk          (clk),
    .i_rstn             (rstn),
    .i_obuf_rstn        (obuf_rstn),
    .i_cam_pclk         (pclk),
    .i_cam_vsync        (vs),
    .i_cam_href         (hr),
    .i_cam_data         (cd),
    .M_AXIS_TREADY      (tready),
    .M_AXIS_TVALID      (tvalid),
    .M_AXIS_TUSER       (tuser),
    .M_AXIS_TLAST       (tlast),
    .M_AXIS_TDATA       (tdata),
    .o_obuf_empty       (empty),
    .o_obuf_almostempty (aempty),
    .o_obuf_fill        (fill),
    .o_ready            (ready)
  );

  typedef struct {
    logic [31:0] d;
    logic        u;
    logic        l;
  } beat_t;

  beat_t q[$];
  int n_chk = 0;
  int n_pass = 0;
  int rdy_mode = 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Scale 5/6-bit channels to 8 bits by plain arithmetic.
  function automatic logic [31:0] model_px(logic [7:0] b0, logic [7:0] b1);
    int r, g, b;
    r = int'(b0) / 8;
    g = (int'(b0) % 8) * 8 + int'(b1) / 32;
    b = int'(b1) % 32;
    return 32'((r * 8 + r / 4) * 65536 + (g * 4 + g / 16) * 256 + b * 8 + b / 4);
  endfunction

  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0: tready = 1'b0;
      1: tready = 1'b1;
      2: tready = ($urandom_range(0, 1) == 1);
      default: tready = ~tready;
    endcase
  end

  logic        prev_stall = 1'b0;
  logic [31:0] prev_d;
  logic        prev_u;
  logic        prev_l;

  initial forever begin
    beat_t e;
    @(negedge clk);
    if (!rstn || !obuf_rstn) begin
      prev_stall = 1'b0;
    end else begin
      chk("ready_vs_empty", ready, !empty);
      chk("empty_vs_fill", empty, fill == 0);
      chk("aempty_vs_fill", aempty, fill <= 1);
      chk("fill_bound", fill <= DEPTH, 1);
      if (prev_stall) begin
        chk("stall_valid", tvalid, 1);
        chk("stall_data", tdata, prev_d);
        chk("stall_user", tuser, prev_u);
        chk("stall_last", tlast, prev_l);
      end
      if (tvalid && tready) begin
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_beat: got %h expected no beat", tdata);
        end else begin
          e = q.pop_front();
          chk("tdata", tdata, e.d);
          chk("tuser", tuser, e.u);
          chk("tlast", tlast, e.l);
        end
      end
      prev_stall = tvalid && !tready;
      prev_d = tdata;
      prev_u = tuser;
      prev_l = tlast;
    end
  end

  task automatic reset_checks();
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tuser", tuser, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_empty", empty, 1);
    chk("rst_aempty", aempty, 1);
    chk("rst_fill", fill, 0);
    chk("rst_ready", ready, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rstn = 1'b0;
    q.delete();
    repeat (3) @(negedge clk);
    reset_checks();
    @(posedge clk);
    #2;
    rstn = 1'b1;
  endtask

  task automatic cam(logic v, logic h, logic [7:0] d);
    @(negedge clk);
    vs = v;
    hr = h;
    cd = d;
    pclk = 1'b1;
    repeat (3) @(negedge clk);
    pclk = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic drain();
    int t;
    t = 0;
    rdy_mode = 2;
    while ((q.size() != 0 || !empty) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_left", q.size(), 0);
  endtask

  // stall>0: hold TREADY low for that many lines, then only the
  // first DEPTH pixels of the frame can survive.
  task automatic frame(int nl, int stall, int rst_y, bit dir, bit rlen);
    int fpx;
    int len;
    int px;
    bit dead;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [31:0] w;
    fpx = 0;
    dead = 0;
    b0 = 8'h00;
    cam(1, 0, 0);
    cam(1, 0, 0);
    cam(0, 0, 0);
    cam(0, 0, 0);
    for (int y = 0; y < nl; y++) begin
      if (stall > 0 && y == stall) begin
        chk("fill_saturated", fill, DEPTH);
        rdy_mode = 2;
      end
      cam(0, 0, 0);
      cam(0, 0, 0);
      len = rlen ? int'($urandom_range(1, 40)) : 2 * W;
      px = 0;
      for (int i = 0; i < len; i++) begin
        if (y == rst_y && i == 10) begin
          do_reset();
          dead = 1;
        end
        if (i % 2 == 0) begin
          b0 = 8'($urandom);
          if (dir && y == 0 && px == 0) b0 = 8'h00;
          if (dir && y == 1 && px == 3) b0 = 8'h18;
          cam(0, 1, b0);
        end else begin
          b1 = 8'($urandom);
          w = model_px(b0, b1);
          if (dir && y == 0 && px == 0) begin
            b1 = 8'h20;
            w = 32'h0000_0400;
          end
          if (dir && y == 1 && px == 3) begin
            b1 = 8'hA1;
            w = 32'h0018_1408;
          end
          if (!dead && (stall == 0 || fpx < DEPTH))
            q.push_back('{w, (fpx == 0), (px % W == W - 1)});
          fpx++;
          px++;
          cam(0, 1, b1);
        end
      end
    end
    cam(0, 0, 0);
  endtask

  initial begin
    #900us;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0;
    repeat (4) @(negedge clk);
    reset_checks();
    @(posedge clk);
    #2;
    rstn = 1'b1;

    rdy_mode = 1;
    frame(2, 0, -1, 1, 0);
    rdy_mode = 2;
    frame(4, 0, -1, 0, 1);
    rdy_mode = 3;
    frame(3, 0, -1, 0, 0);

    drain();
    rdy_mode = 0;
    frame(18, 17, -1, 0, 0);
    rdy_mode = 1;
    frame(2, 0, -1, 0, 0);

    drain();
    rdy_mode = 0;
    frame(2, 0, -1, 0, 0);
    @(posedge clk);
    #2;
    obuf_rstn = 1'b0;
    q.delete();
    @(posedge clk);
    #2;
    obuf_rstn = 1'b1;
    @(negedge clk);
    chk("flush_fill", fill, 0);
    chk("flush_empty", empty, 1);

    rdy_mode = 1;
    frame(2, 0, -1, 0, 1);
    frame(3, 0, 1, 0, 0);
    frame(2, 0, -1, 0, 0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
